prog_fetch_unit: RTL
====================

# prog_fetch_unit

Instruction-fetch sequencer for the RAT MCU: owns the program counter, drives the 10-bit address into the 1024x18 synchronous program ROM, and captures the returned 18-bit instruction into a holding register. It sits directly upstream of the ROM and hands instructions to the control unit through a valid/ack handshake. It also selects the next PC from sequential, branch, return and interrupt-vector sources.

## Interface
- ADDR_W, 10, PC / ROM address width
- IR_W, 18, instruction width
- RESET_VEC, 10'h000, PC after reset
- INTR_VEC, 10'h3FF, interrupt service routine entry address
- CLK  in  1  system clock; all state changes on rising edge
- RESET_N  in  1  synchronous, active-low reset
- PROG_ADDR  out  ADDR_W  address to ROM; combinational copy of PC register
- PROG_IR  in  IR_W  ROM data; valid one cycle after PROG_ADDR is presented (ROM registers on CLK)
- INSTR  out  IR_W  held instruction for control unit
- INSTR_VALID  out  1  INSTR is stable and awaiting execution
- INSTR_ACK  in  1  control unit finished INSTR; sampled only while INSTR_VALID=1
- PC  out  ADDR_W  address of the instruction in INSTR
- BR_TAKEN  in  1  at ack: next PC = BR_ADDR
- BR_ADDR  in  ADDR_W  branch/call target
- RET  in  1  at ack: next PC = RET_ADDR (RET/RETIE)
- RET_ADDR  in  ADDR_W  return address popped by control unit
- INTR  in  1  level interrupt request
- INTR_EN  in  1  interrupt enable flag from control unit
- INTR_TAKEN  out  1  one-cycle pulse: interrupt accepted
- RET_PC  out  ADDR_W  address the ISR must return to; valid from INTR_TAKEN until next interrupt
- IN_ISR  out  1  executing inside ISR

## Operation
- States: FETCH, LATCH, EXEC.
- FETCH: PROG_ADDR=PC; unconditionally -> LATCH.
- LATCH: PROG_IR valid; INSTR<=PROG_IR; -> EXEC.
- EXEC: INSTR_VALID=1. INSTR_ACK=0: stay, all outputs held. INSTR_ACK=1: load next PC, -> FETCH.
- Next-PC priority at ack (highest first):
  - INTR & INTR_EN & !IN_ISR: PC<=INTR_VEC; RET_PC<=the PC the lower priorities would have chosen; IN_ISR<=1; INTR_TAKEN=1 for one cycle.
  - BR_TAKEN: PC<=BR_ADDR (wins over simultaneous RET).
  - RET: PC<=RET_ADDR; if IN_ISR, IN_ISR<=0.
  - else PC<=PC+1, modulo 2^ADDR_W (0x3FF+1 wraps to 0x000).
- INTR not sampled outside EXEC-with-ack; a request deasserted before ack is lost (no latching).
- Nested interrupts blocked while IN_ISR=1.
- RESET_N=0 at any edge, any state: PC=RESET_VEC, INSTR=0, INSTR_VALID=0, RET_PC=0, IN_ISR=0, INTR_TAKEN=0, state=FETCH; in-flight instruction discarded.

## Timing
- Reset values: PROG_ADDR=RESET_VEC, PC=RESET_VEC, INSTR=18'h0, INSTR_VALID=0, INTR_TAKEN=0, RET_PC=0, IN_ISR=0.
- First INSTR_VALID: 2 cycles after the edge releasing reset (FETCH, LATCH, then EXEC).
- Throughput: 3 cycles/instruction with INSTR_ACK held high; each cycle of ack delay adds one.
- Edge with ack in EXEC: PC and PROG_ADDR update; INSTR_VALID falls; INTR_TAKEN rises (interrupt case) for exactly one cycle.
- INSTR and PC change only on the LATCH->EXEC edge and the ack edge respectively; never mid-EXEC.
- INSTR_ACK, BR_TAKEN, RET, INTR ignored in FETCH and LATCH.

## Test plan
- Reset, ROM words 0x00000, 0x00001, 0x00002 at 0..2, ack tied 1 -> INSTR_VALID at cycles 2, 5, 8 with PC=0,1,2 and INSTR matching ROM.
- Ack delayed 4 cycles in EXEC -> INSTR, PC, PROG_ADDR constant throughout; next fetch starts the edge after ack.
- PC=0x020, ack with BR_TAKEN=1, BR_ADDR=0x150, RET=1, RET_ADDR=0x077 -> next PC=0x150.
- PC=0x3FF, plain ack -> next PC=0x000.
- PC=0x040, INTR=1, INTR_EN=1, BR_TAKEN=1, BR_ADDR=0x100 at ack -> PC=0x3FF, RET_PC=0x100, IN_ISR=1, one-cycle INTR_TAKEN; second INTR inside ISR ignored; RET with RET_ADDR=0x100 -> PC=0x100, IN_ISR=0.
- RESET_N low for one edge while in EXEC with IN_ISR=1 -> all outputs at reset values next cycle, INSTR_VALID again 2 cycles after release.

Source files
------------

// File: rtl/prog_fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, addresses the synchronous program ROM,
// holds the returned instruction for the control unit and selects the next PC.
module prog_fetch_unit #(
    parameter int                ADDR_W    = 10,
    parameter int                IR_W      = 18,
    parameter logic [ADDR_W-1:0] RESET_VEC = 10'h000,
    parameter logic [ADDR_W-1:0] INTR_VEC  = 10'h3FF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    output logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [IR_W-1:0]   PROG_IR,
    output logic [IR_W-1:0]   INSTR,
    output logic              INSTR_VALID,
    input  logic              INSTR_ACK,
    output logic [ADDR_W-1:0] PC,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_ADDR,
    input  logic              RET,
    input  logic [ADDR_W-1:0] RET_ADDR,
    input  logic              INTR,
    input  logic              INTR_EN,
    output logic              INTR_TAKEN,
    output logic [ADDR_W-1:0] RET_PC,
    output logic              IN_ISR
);

    typedef enum logic [1:0] {FETCH, LATCH, EXEC} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [IR_W-1:0]   instr_q;
    logic              vld_q;
    logic [ADDR_W-1:0] ret_pc_q;
    logic              in_isr_q;
    logic              intr_taken_q;

    logic [ADDR_W-1:0] seq_pc_d;
    logic [ADDR_W-1:0] alt_pc_d;
    logic              take_intr_d;

    // alt_pc_d is the target ignoring interrupts; it also becomes the ISR return address
    always_comb begin
        seq_pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        alt_pc_d    = BR_TAKEN ? BR_ADDR : (RET ? RET_ADDR : seq_pc_d);
        take_intr_d = INTR & INTR_EN & ~in_isr_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q      <= FETCH;
            pc_q         <= RESET_VEC;
            instr_q      <= '0;
            vld_q        <= 1'b0;
            ret_pc_q     <= '0;
            in_isr_q     <= 1'b0;
            intr_taken_q <= 1'b0;
        end else begin
            intr_taken_q <= 1'b0;
            case (state_q)
                FETCH: state_q <= LATCH;
                LATCH: begin
                    instr_q <= PROG_IR;
                    vld_q   <= 1'b1;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (INSTR_ACK) begin
                        vld_q   <= 1'b0;
                        state_q <= FETCH;
                        if (take_intr_d) begin
                            pc_q         <= INTR_VEC;
                            ret_pc_q     <= alt_pc_d;
                            in_isr_q     <= 1'b1;
                            intr_taken_q <= 1'b1;
                        end else begin
                            pc_q <= alt_pc_d;
                            if (!BR_TAKEN && RET) begin
                                in_isr_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign PROG_ADDR   = pc_q;
    assign PC          = pc_q;
    assign INSTR       = instr_q;
    assign INSTR_VALID = vld_q;
    assign RET_PC      = ret_pc_q;
    assign IN_ISR      = in_isr_q;
    assign INTR_TAKEN  = intr_taken_q;

endmodule
